// File: rtl/cam_dvp_tx.sv
// DVP camera-sensor source: pixel clock, VSYNC, HREF and byte data for fixed frame geometry.
// Define CAM_TX_STREAM_EN to take HREF bytes from a valid/ready stream instead of the pattern.
module cam_dvp_tx #(
    parameter int unsigned H_ACTIVE  = 16,
    parameter int unsigned BPP       = 2,
    parameter int unsigned H_BLANK   = 8,
    parameter int unsigned V_ACTIVE  = 4,
    parameter int unsigned VSYNC_LEN = 4,
    parameter int unsigned V_BP      = 8,
    parameter int unsigned V_FP      = 8,
    parameter int unsigned PCLK_DIV  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        single_i,
`ifdef CAM_TX_STREAM_EN
    input  logic [7:0]  s_data_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    output logic        underrun_o,
`endif
    output logic        cam_pclk_o,
    output logic        cam_vsync_o,
    output logic        cam_href_o,
    output logic [7:0]  cam_data_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic [15:0] frame_cnt_o
);

    localparam int unsigned LineLen = H_ACTIVE * BPP;
    localparam int unsigned DivW    = $clog2(PCLK_DIV);

    typedef enum logic [2:0] {StIdle, StVsync, StVbp, StLine, StHblank, StVfp} state_e;

    state_e            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d, line_q, line_d;
    logic [DivW-1:0]   div_q, div_d;
    logic              pclk_q, pclk_d;
    logic              vsync_q, vsync_d, href_q, href_d;
    logic [7:0]        data_q, data_d;
    logic              single_q, single_d;
    logic              done_q, done_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [15:0]       seg_len, cnt_inc;
    logic              tick, pre_tick, seg_last, last_line, next_is_line;

    // tick: this clk ends a pclk period; pre_tick: the next clk does.
    assign tick      = (div_q == DivW'(PCLK_DIV - 1));
    assign pre_tick  = (div_q == DivW'(PCLK_DIV - 2));
    assign div_d     = tick ? '0 : div_q + DivW'(1);
    assign pclk_d    = (div_d >= DivW'(PCLK_DIV / 2));
    assign cnt_inc   = cnt_q + 16'd1;
    assign seg_last  = (cnt_q == seg_len - 16'd1);
    assign last_line = (line_q == 16'(V_ACTIVE - 1));

    always_comb begin
        seg_len = 16'd1;
        unique case (state_q)
            StVsync:  seg_len = 16'(VSYNC_LEN);
            StVbp:    seg_len = 16'(V_BP);
            StLine:   seg_len = 16'(LineLen);
            StHblank: seg_len = 16'(H_BLANK);
            StVfp:    seg_len = 16'(V_FP);
            default:  seg_len = 16'd1;
        endcase
    end

    // The period after the coming boundary carries an active byte.
    assign next_is_line = ((state_q == StVbp) && seg_last) ||
                          ((state_q == StHblank) && seg_last && !last_line) ||
                          ((state_q == StLine) && !seg_last);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        line_d   = line_q;
        single_d = single_q | ((state_q == StIdle) & single_i);
        if (tick) begin
            unique case (state_q)
                StIdle: begin
                    if (en_i || single_d) begin
                        state_d  = StVsync;
                        cnt_d    = '0;
                        single_d = 1'b0;
                    end
                end
                StVsync: begin
                    if (seg_last) begin
                        state_d = StVbp;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StVbp: begin
                    if (seg_last) begin
                        state_d = StLine;
                        cnt_d   = '0;
                        line_d  = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StLine: begin
                    if (seg_last) begin
                        state_d = StHblank;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StHblank: begin
                    if (seg_last) begin
                        cnt_d = '0;
                        if (last_line) begin
                            state_d = StVfp;
                        end else begin
                            state_d = StLine;
                            line_d  = line_q + 16'd1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StVfp: begin
                    if (seg_last) begin
                        cnt_d   = '0;
                        state_d = en_i ? StVsync : StIdle;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign vsync_d     = (state_d == StVsync);
    assign href_d      = (state_d == StLine);
    assign done_d      = pre_tick && (state_q == StVfp) && seg_last;
    assign frame_cnt_d = done_d ? frame_cnt_q + 16'd1 : frame_cnt_q;

`ifdef CAM_TX_STREAM_EN
    logic ready_q, ready_d, underrun_q, underrun_d;

    assign ready_d = pre_tick && next_is_line;

    always_comb begin
        underrun_d = underrun_q;
        if (tick && (state_d == StLine) && !(s_valid_i && ready_q)) begin
            underrun_d = 1'b1;
        end
        if ((state_q == StIdle) && !en_i) begin
            underrun_d = 1'b0;
        end
    end
`endif

    always_comb begin
        data_d = data_q;
        if (tick) begin
            if (state_d == StLine) begin
`ifdef CAM_TX_STREAM_EN
                data_d = (s_valid_i && ready_q) ? s_data_i : 8'hFF;
`else
                data_d = {line_d[3:0], 4'h0} + cnt_d[7:0];
`endif
            end else begin
                data_d = 8'h00;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            line_q      <= '0;
            div_q       <= '0;
            pclk_q      <= 1'b0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            data_q      <= 8'h00;
            single_q    <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_q      <= line_d;
            div_q       <= div_d;
            pclk_q      <= pclk_d;
            vsync_q     <= vsync_d;
            href_q      <= href_d;
            data_q      <= data_d;
            single_q    <= single_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

`ifdef CAM_TX_STREAM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            ready_q    <= ready_d;
            underrun_q <= underrun_d;
        end
    end

    assign s_ready_o  = ready_q;
    assign underrun_o = underrun_q;
`endif

    assign cam_pclk_o   = pclk_q;
    assign cam_vsync_o  = vsync_q;
    assign cam_href_o   = href_q;
    assign cam_data_o   = data_q;
    assign busy_o       = (state_q != StIdle);
    assign frame_done_o = done_q;
    assign frame_cnt_o  = frame_cnt_q;

endmodule
